// File: rtl/mt_seed_expander.sv
// mt_seed_expander: expands one W-bit seed into the N-word MT19937 initial
// state using the init_genrand recurrence, streaming the words in index
// order over a valid/ready style load port.
//
// Ports:
//   clk        in   system clock (posedge)
//   n_rst      in   asynchronous active-low reset
//   start      in   request expansion; only honoured while idle
//   seed       in   seed word, captured when start is accepted
//   ready      in   downstream accepts value this cycle
//   load_value out  value carries a valid state word
//   value      out  current state word x[idx]
//   busy       out  high while words are being streamed
//   done       out  one-cycle pulse after the last word transfers
module mt_seed_expander #(
  parameter int unsigned    W = 32,
  parameter int unsigned    N = 624,
  parameter logic [W-1:0]   F = W'(32'h6C078965)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  input  logic         ready,
  output logic         load_value,
  output logic [W-1:0] value,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_x;
  logic           r_load;
  logic           r_busy;
  logic           r_done;

  logic [W-1:0]   w_mix;
  logic [W-1:0]   w_x_next;
  logic           w_xfer;

  // Recurrence; products and sums are taken in W bits so they wrap mod 2^W.
  assign w_mix    = r_x ^ (r_x >> 30);
  assign w_x_next = (F * w_mix) + W'(r_idx) + W'(1);
  assign w_xfer   = r_load & ready;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_STREAM;
            r_x     <= seed;
            r_idx   <= '0;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_load  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= IW'(r_idx + IW'(1));
              r_x   <= w_x_next;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign load_value = r_load;
  assign value      = r_x;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_mt_seed_expander.sv
// Self-checking bench for mt_seed_expander: compares streamed words against
// an array-based init_genrand model and runs the MT19937 twist/temper on the
// captured state to confirm the known first generator outputs.
module tb_mt_seed_expander;

  localparam int unsigned N = 624;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] seed;
  logic        ready;
  logic        load_value;
  logic [31:0] value;
  logic        busy;
  logic        done;

  int total;
  int bad;

  logic [31:0] ref_w [N];
  logic [31:0] got_q [$];
  int          done_cnt;
  int          done_cyc;
  int          last_xfer_cyc;

  mt_seed_expander dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .seed       (seed),
    .ready      (ready),
    .load_value (load_value),
    .value      (value),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: x[0]=seed, x[i] = F*(x[i-1] ^ (x[i-1]>>30)) + i  (mod 2^32)
  task automatic gen_ref(input logic [31:0] s);
    longint unsigned x;
    x = longint'(s);
    ref_w[0] = s;
    for (int i = 1; i < N; i++) begin
      x = ((64'd1812433253 * (x ^ (x >> 30))) + longint'(i)) & 64'hFFFF_FFFF;
      ref_w[i] = x[31:0];
    end
  endtask

  // Accept start on the next posedge and check the first word appears right after.
  task automatic kick(input logic [31:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    total++;
    if (load_value !== 1'b1 || busy !== 1'b1 || value !== s) begin
      bad++;
      $display("FAIL first_word lv=%b busy=%b value=%0d want lv=1 busy=1 value=%0d",
               load_value, busy, value, s);
    end
  endtask

  // Drive ready per mode (0 always, 1 alternating, 2 random) and collect transfers.
  // noisy=1 throws random start/seed at the DUT while it streams and on done.
  task automatic collect(input int mode, input bit noisy);
    bit          lv, rdy, prev_hold, d;
    logic [31:0] v, prev_v;
    int          cyc;
    int          tail;
    got_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    last_xfer_cyc = -1;
    prev_hold     = 1'b0;
    prev_v        = '0;
    tail          = -1;
    cyc           = 0;
    while (cyc < 5000 && tail != 0) begin
      if (cyc > 0) @(negedge clk);
      lv = load_value;
      v  = value;
      d  = done;
      if (prev_hold) begin
        total++;
        if (lv !== 1'b1 || v !== prev_v) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d lv=%b value=%0d want lv=1 value=%0d",
                   cyc, lv, v, prev_v);
        end
      end
      if (d) begin
        done_cnt++;
        done_cyc = cyc;
        tail     = 4;
      end else if (tail > 0) begin
        tail--;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready = rdy;
      if (noisy) begin
        start = d ? 1'b1 : 1'($urandom_range(0, 1));
        seed  = $urandom;
        if (tail >= 0 && !d) start = 1'b0;
      end
      prev_hold = lv && !rdy;
      prev_v    = v;
      @(posedge clk);
      if (lv && rdy) begin
        got_q.push_back(v);
        last_xfer_cyc = cyc;
      end
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    total++;
    if (tail != 0) begin
      bad++;
      $display("FAIL stream_timeout cycles=%0d transfers=%0d want done within 5000", cyc, got_q.size());
    end
  endtask

  task automatic check_seq(input string tag);
    int nerr;
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", tag, got_q.size(), N);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt);
    end
    total++;
    if (done_cyc != last_xfer_cyc + 1) begin
      bad++;
      $display("FAIL %s_done_timing got_cyc=%0d want_cyc=%0d", tag, done_cyc, last_xfer_cyc + 1);
    end
    nerr = 0;
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== ref_w[i]) begin
        bad++;
        nerr++;
        if (nerr <= 5)
          $display("FAIL %s_word[%0d] got=%0d want=%0d", tag, i, got_q[i], ref_w[i]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (load_value !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s_idle lv=%b busy=%b done=%b want 0/0/0", tag, load_value, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    kick(32'd5489);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (load_value !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || value !== 32'd0) begin
      bad++;
      $display("FAIL reset_async lv=%b busy=%b done=%b value=%0d want all 0",
               load_value, busy, done, value);
    end
    @(negedge clk);
    n_rst = 1'b1;
    check_idle("after_reset");
  endtask

  task automatic test_seed_5489();
    gen_ref(32'd5489);
    kick(32'd5489);
    collect(0, 1'b0);
    check_seq("s5489");
    total++;
    if (got_q.size() < 2 || got_q[0] !== 32'd5489 || got_q[1] !== 32'h4D98EE96) begin
      bad++;
      $display("FAIL s5489_known_words got_count=%0d want word0=5489 word1=1301868182", got_q.size());
    end
    check_idle("s5489");
  endtask

  task automatic test_seed_zero();
    gen_ref(32'd0);
    kick(32'd0);
    collect(0, 1'b0);
    check_seq("s0");
    total++;
    if (got_q.size() < 3 || got_q[0] !== 32'd0 || got_q[1] !== 32'd1 || got_q[2] !== 32'd1812433255) begin
      bad++;
      $display("FAIL s0_known_words got_count=%0d want 0,1,1812433255", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    gen_ref(32'd5489);
    kick(32'd5489);
    collect(1, 1'b0);
    check_seq("bp_alt");
    kick(32'd5489);
    collect(2, 1'b0);
    check_seq("bp_rand");
    for (int k = 0; k < 2; k++) begin
      logic [31:0] s;
      s = $urandom;
      gen_ref(s);
      kick(s);
      collect(2, 1'b0);
      check_seq("bp_rand_seed");
    end
  endtask

  task automatic test_start_ignored();
    gen_ref(32'd5489);
    kick(32'd5489);
    collect(0, 1'b1);
    check_seq("ign");
    check_idle("ign");
    kick(32'd5489);
    collect(2, 1'b1);
    check_seq("ign_restart");
  endtask

  task automatic test_integration();
    logic [31:0] mt [N];
    logic [31:0] y;
    logic [31:0] outs [10];
    logic [31:0] exp3 [3];
    gen_ref(32'd5489);
    kick(32'd5489);
    collect(0, 1'b0);
    for (int i = 0; i < N; i++) mt[i] = (i < got_q.size()) ? got_q[i] : 32'd0;
    for (int i = 0; i < N; i++) begin
      y = (mt[i] & 32'h8000_0000) | (mt[(i + 1) % N] & 32'h7FFF_FFFF);
      mt[i] = mt[(i + 397) % N] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      y = mt[i];
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 32'h9D2C_5680);
      y = y ^ ((y << 15) & 32'hEFC6_0000);
      y = y ^ (y >> 18);
      outs[i] = y;
    end
    exp3[0] = 32'd3499211612;
    exp3[1] = 32'd581869302;
    exp3[2] = 32'd3890346734;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== exp3[i]) begin
        bad++;
        $display("FAIL mt_output[%0d] got=%0d want=%0d", i, outs[i], exp3[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    start = 1'b0;
    seed  = '0;
    ready = 1'b1;
    #1;
    total++;
    if (load_value !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || value !== 32'd0) begin
      bad++;
      $display("FAIL reset_state lv=%b busy=%b done=%b value=%0d want all 0",
               load_value, busy, done, value);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    check_idle("init");

    test_reset();
    test_seed_5489();
    test_seed_zero();
    test_backpressure();
    test_start_ignored();
    test_integration();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
